// File: rtl/dsp_mac_sequencer_if.sv
// Bundle of the control, operand-stream, DSP-slice and result signals of the
// MAC sequencer. The sequencer itself uses the slave view.
interface dsp_mac_sequencer_if #(
    parameter int SIZE1 = 18,
    parameter int SIZE3 = 48,
    parameter int LENW  = 10
);
    logic             start;
    logic [LENW-1:0]  len;
    logic             busy;

    logic             s_valid;
    logic             s_ready;
    logic [SIZE1-1:0] s_a;
    logic [SIZE1-1:0] s_b;

    logic [SIZE1-1:0] dsp_a;
    logic [SIZE1-1:0] dsp_b;
    logic [7:0]       dsp_opmode;
    logic             dsp_cea;
    logic             dsp_ceb;
    logic             dsp_cem;
    logic             dsp_cep;
    logic             dsp_rst;
    logic [SIZE3-1:0] dsp_p;

    logic             res_valid;
    logic             res_ready;
    logic [SIZE3-1:0] res_data;

    modport slave (
        input  start, len, s_valid, s_a, s_b, dsp_p, res_ready,
        output busy, s_ready, dsp_a, dsp_b, dsp_opmode,
               dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rst,
               res_valid, res_data
    );

    modport master (
        output start, len, s_valid, s_a, s_b, dsp_p, res_ready,
        input  busy, s_ready, dsp_a, dsp_b, dsp_opmode,
               dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rst,
               res_valid, res_data
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Sequences a dot product through an external DSP slice (A1/B1 -> M -> P):
// issues clock enables and OPMODE, then captures the final P as the result.
module dsp_mac_sequencer #(
    parameter int SIZE1 = 18,
    parameter int SIZE3 = 48,
    parameter int LENW  = 10
) (
    input logic                CLK,
    input logic                RST,
    dsp_mac_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t           r_state;
    logic [LENW-1:0]  r_cnt;
    logic             r_pend;
    logic [3:1]       r_vld;
    logic [3:1]       r_first;
    logic [SIZE3-1:0] r_res;
    logic             r_busy;
    logic             r_s_ready;
    logic             r_res_valid;

    logic             w_acc;
    logic             w_last_out;

    assign w_acc      = bus.s_valid & r_s_ready & ~RST;
    // Only the last sample is left in flight once it sits alone in stage 3.
    assign w_last_out = r_vld[3] & ~r_vld[2] & ~r_vld[1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_vld       <= '0;
            r_first     <= '0;
            r_res       <= '0;
            r_busy      <= 1'b0;
            r_s_ready   <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_vld   <= {r_vld[2:1], w_acc};
            r_first <= {r_first[2:1], w_acc & r_pend};
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (bus.len != '0) begin
                            r_state   <= ACCUM;
                            r_cnt     <= bus.len;
                            r_pend    <= 1'b1;
                            r_s_ready <= 1'b1;
                        end else begin
                            r_state     <= DONE;
                            r_res       <= '0;
                            r_res_valid <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (w_acc) begin
                        r_pend <= 1'b0;
                        r_cnt  <= r_cnt - 1'b1;
                        if (r_cnt == LENW'(1)) begin
                            r_state   <= DRAIN;
                            r_s_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (w_last_out) begin
                        r_state     <= DONE;
                        r_res       <= bus.dsp_p;
                        r_res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_res_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.s_ready   = r_s_ready & ~RST;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res;

    assign bus.dsp_a   = bus.s_a;
    assign bus.dsp_b   = bus.s_b;
    assign bus.dsp_cea = w_acc;
    assign bus.dsp_ceb = w_acc;
    assign bus.dsp_cem = r_vld[1] & ~RST;
    assign bus.dsp_cep = r_vld[2] & ~RST;
    assign bus.dsp_rst = RST;
    // First product of a job overwrites P (Z=0); the rest accumulate (Z=P).
    assign bus.dsp_opmode = RST ? 8'h00 : (r_first[1] ? 8'h01 : 8'h09);
endmodule

// File: doc/dsp_mac_sequencer.md
DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 The block SHALL have parameter SIZE1, default 18, meaning the operand width (A/B).
REQ-002 The block SHALL have parameter SIZE3, default 48, meaning the accumulator/P width.
REQ-003 The block SHALL have parameter LENW, default 10, meaning the width of the sample-count field.
REQ-004 The block SHALL have port CLK, input, 1 bit, the single clock; all logic rising-edge.
REQ-005 The block SHALL have port RST, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit, a one-cycle request to begin a dot product; ignored unless IDLE.
REQ-007 The block SHALL have port len, input, LENW bits, the number of sample pairs, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not IDLE.
REQ-009 The block SHALL have ports s_valid (input, 1 bit), s_ready (output, 1 bit), s_a (input, SIZE1 bits) and s_b (input, SIZE1 bits), forming the operand stream.
REQ-010 The block SHALL have ports dsp_a and dsp_b, output, SIZE1 bits each, driving the slice A/B inputs (combinational from s_a/s_b).
REQ-011 The block SHALL have port dsp_opmode, output, 8 bits, driving the slice OPMODE input; the slice has OPMODEREG=1 and CEOPMODE tied high.
REQ-012 The block SHALL have ports dsp_cea, dsp_ceb, dsp_cem and dsp_cep, output, 1 bit each, the slice clock enables.
REQ-013 The block SHALL have port dsp_rst, output, 1 bit, driving slice RSTA/RSTB/RSTM/RSTP/RSTOPMODE.
REQ-014 The block SHALL have port dsp_p, input, SIZE3 bits, the slice P output. The slice is configured A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, B_INPUT="DIRECT", with the pre-adder bypassed.
REQ-015 The block SHALL have ports res_valid (output, 1 bit), res_ready (input, 1 bit) and res_data (output, SIZE3 bits), forming the result handshake.

Function
REQ-016 The FSM SHALL have the states IDLE, ACCUM, DRAIN and DONE.
REQ-017 In IDLE, start=1 with len>0 SHALL load the remaining-count register with len and go to ACCUM.
REQ-018 In IDLE, start=1 with len=0 SHALL go directly to DONE with res_data=0, without issuing any slice enables.
REQ-019 s_ready SHALL be 1 only in ACCUM while the remaining count is >0; a sample is accepted on any cycle where s_valid and s_ready are both 1.
REQ-020 On an accepted sample, dsp_cea and dsp_ceb SHALL be 1 in the same cycle; otherwise they SHALL be 0.
REQ-021 The block SHALL carry a 3-stage tag pipeline (valid, first) in lockstep with the slice A1/B1, M and P registers; the first tag is set for sample 1 of a job.
REQ-022 dsp_cem SHALL equal the stage-1 valid tag.
REQ-023 dsp_cep SHALL equal the stage-2 valid tag.
REQ-024 Bubbles caused by s_valid=0 SHALL leave M and P unchanged.
REQ-025 dsp_opmode SHALL be driven from the stage-1 tag: 8'h01 (X=M, Z=0) when first=1, and 8'h09 (X=M, Z=P) otherwise. Bits 7:4 SHALL always be 0 (add, no pre-adder, CIN=0).
REQ-026 Latency from the accept of sample k to that sample's product being included in P SHALL be 3 cycles.
REQ-027 When the last sample is accepted, the FSM SHALL go from ACCUM to DRAIN.
REQ-028 In DRAIN, once the stage-3 tag of the last sample is valid (P holds the final sum), the block SHALL capture dsp_p into res_data and go to DONE.
REQ-029 In DONE, res_valid SHALL be 1 and res_data SHALL be held stable until res_ready=1; the FSM then returns to IDLE on the next edge.
REQ-030 A start seen in the same cycle as the DONE handshake completes SHALL be ignored.
REQ-031 Accumulation SHALL be modulo 2^SIZE3, with no saturation or overflow flag.
REQ-032 The block SHALL perform no arithmetic itself; all sums are computed in the slice.

Reset
REQ-033 RST=1 SHALL, at the next edge, set the FSM to IDLE and clear the count, tags and res_data.
REQ-034 During RST, dsp_rst SHALL equal RST (combinational) and all dsp_ce* outputs SHALL be 0.
REQ-035 Reset values SHALL be: busy=0, s_ready=0, res_valid=0, res_data=0, dsp_opmode=8'h00, dsp_ce*=0.
REQ-036 RST asserted mid-job SHALL abort the job, produce no result, and leave the block accepting start on the first cycle after RST falls.

Verification
REQ-037 A bench SHALL cover: len=3, pairs (2,3),(4,5),(-1,7) streamed back-to-back -> res_valid with res_data=19, with busy falling after the res_ready handshake.
REQ-038 A bench SHALL cover: len=4, all pairs (1,1), with s_valid deasserted for 2 cycles between pairs 2 and 3 -> res_data=4, and dsp_cep pulsed exactly 4 times.
REQ-039 A bench SHALL cover: len=0 start -> res_valid one cycle later with res_data=0, and dsp_cea/ceb/cem/cep never asserted.
REQ-040 A bench SHALL cover: a result held with res_ready=0 for 5 cycles -> res_data stable, s_ready=0, and start ignored during that time.
REQ-041 A bench SHALL cover: RST pulsed after 2 of 5 samples -> busy=0 the next cycle, no res_valid, and a subsequent len=1 job of (6,7) -> res_data=42.
REQ-042 A bench SHALL cover: two jobs back-to-back, (3,3) then (2,2) -> results 9 then 4, with the second job not contaminated by the first job's P.
